// File: rtl/pi_rx_pkg.sv
// rtl/pi_rx_pkg.sv - shared state encoding and default sizes for the Pi receive buffer
package pi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } pi_rx_state_e;

    localparam int PI_RX_DATA_W = 8;
    localparam int PI_RX_DEPTH  = 16;
    localparam int PI_RX_LED_W  = 6;

endpackage

// File: rtl/pi_rx_regfile.sv
// rtl/pi_rx_regfile.sv - frame word storage: one write port, combinational consumer and debug read ports
module pi_rx_regfile
    import pi_rx_pkg::*;
#(
    parameter int DATA_W = PI_RX_DATA_W,
    parameter int DEPTH  = PI_RX_DEPTH,
    parameter int LED_W  = PI_RX_LED_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              pi_clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic [AW-1:0]     i_led_sel,
    output logic [LED_W-1:0]  o_led
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // rst_n is active-high here: the whole array clears while it is asserted
    always_ff @(posedge pi_clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    logic [DATA_W-1:0] w_led_word;

    assign o_rd_data  = r_mem[i_rd_addr];
    assign w_led_word = r_mem[i_led_sel];
    assign o_led      = w_led_word[LED_W-1:0];

endmodule

// File: rtl/pi_rx_buffer.sv
// rtl/pi_rx_buffer.sv - frames GPIO words from the Pi into a buffer with count, overflow and frame status
module pi_rx_buffer
    import pi_rx_pkg::*;
#(
    parameter int DATA_W = PI_RX_DATA_W,
    parameter int DEPTH  = PI_RX_DEPTH,
    parameter int LED_W  = PI_RX_LED_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              pi_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] gpio_data,
    input  logic              wr_en,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [AW-1:0]     led_sel,
    output logic [LED_W-1:0]  led,
    output logic              wr_ready,
    output logic              frame_valid,
    output logic [AW:0]       count,
    output logic              overflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    pi_rx_state_e r_state;
    pi_rx_state_e w_state_nxt;
    logic [AW:0]  r_count;
    logic [AW:0]  w_count_nxt;
    logic [AW:0]  w_count_inc;
    logic         r_overflow;
    logic         w_overflow_nxt;
    logic         w_has_room;
    logic         w_we;

    assign w_has_room  = (r_count < DEPTH_C);
    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge pi_clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // frame_start outranks everything; in RECV a write lands before frame_end closes the frame
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_we           = 1'b0;
        case (r_state)
            RECV: begin
                if (frame_start) begin
                    w_count_nxt    = '0;
                    w_overflow_nxt = 1'b0;
                end else begin
                    if (wr_en) begin
                        if (w_has_room) begin
                            w_we        = 1'b1;
                            w_count_nxt = w_count_inc;
                            if (w_count_inc == DEPTH_C) begin
                                w_state_nxt = DONE;
                            end
                        end else begin
                            w_overflow_nxt = 1'b1;
                        end
                    end
                    if (frame_end) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            IDLE, DONE: begin
                if (frame_start) begin
                    w_state_nxt    = RECV;
                    w_count_nxt    = '0;
                    w_overflow_nxt = 1'b0;
                end else if (wr_en) begin
                    w_overflow_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    pi_rx_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LED_W  (LED_W)
    ) u_regfile (
        .pi_clk    (pi_clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_waddr   (r_count[AW-1:0]),
        .i_wdata   (gpio_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .i_led_sel (led_sel),
        .o_led     (led)
    );

    assign wr_ready    = (r_state == RECV) && w_has_room;
    assign frame_valid = (r_state == DONE);
    assign count       = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_pi_rx_buffer.sv
// tb/tb_pi_rx_buffer.sv - scoreboard bench for pi_rx_buffer
module tb_pi_rx_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LED_W  = 6;
    localparam int AW     = 4;

    localparam int K_CNT = 0;
    localparam int K_OVF = 1;
    localparam int K_VAL = 2;
    localparam int K_RDY = 3;
    localparam int K_RD  = 4;
    localparam int K_LED = 5;

    logic              pi_clk = 1'b0;
    logic              rst_n  = 1'b0;
    logic [DATA_W-1:0] gpio_data = '0;
    logic              wr_en = 1'b0;
    logic              frame_start = 1'b0;
    logic              frame_end = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic [AW-1:0]     led_sel = '0;
    logic [LED_W-1:0]  led;
    logic              wr_ready;
    logic              frame_valid;
    logic [AW:0]       count;
    logic              overflow;

    pi_rx_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LED_W  (LED_W)
    ) dut (
        .pi_clk      (pi_clk),
        .rst_n       (rst_n),
        .gpio_data   (gpio_data),
        .wr_en       (wr_en),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .led_sel     (led_sel),
        .led         (led),
        .wr_ready    (wr_ready),
        .frame_valid (frame_valid),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 pi_clk = ~pi_clk;

    typedef struct {
        string       nm;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    event chk_ev;

    function automatic logic [31:0] observe(int kind);
        case (kind)
            K_CNT:   return 32'(count);
            K_OVF:   return 32'(overflow);
            K_VAL:   return 32'(frame_valid);
            K_RDY:   return 32'(wr_ready);
            K_RD:    return 32'(rd_data);
            K_LED:   return 32'(led);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = observe(e.kind);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s actual=0x%0h expected=0x%0h", e.nm, act, e.exp);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge pi_clk or chk_ev);
            drain();
        end
    end

    task automatic expect_v(input string nm, input int kind, input logic [31:0] v);
        exp_t e;
        e.nm   = nm;
        e.kind = kind;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic flush();
        @(negedge pi_clk);
        #1;
    endtask

    task automatic rd_chk(input string nm, input int a, input logic [31:0] v);
        rd_addr = AW'(a);
        expect_v(nm, K_RD, v);
        flush();
    endtask

    task automatic led_chk(input string nm, input int a, input logic [31:0] v);
        led_sel = AW'(a);
        expect_v(nm, K_LED, v);
        flush();
    endtask

    task automatic cyc(input logic we, input logic [7:0] d, input logic fs, input logic fe);
        wr_en       = we;
        gpio_data   = d;
        frame_start = fs;
        frame_end   = fe;
        @(posedge pi_clk);
        #1;
        wr_en       = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
    endtask

    task automatic status(input string tag, input int c, input int ov, input int v, input int r);
        expect_v({tag, "_count"}, K_CNT, 32'(c));
        expect_v({tag, "_ovf"},   K_OVF, 32'(ov));
        expect_v({tag, "_valid"}, K_VAL, 32'(v));
        expect_v({tag, "_ready"}, K_RDY, 32'(r));
        flush();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b1;
        repeat (2) @(posedge pi_clk);
        #1;
        status("reset", 0, 0, 0, 0);
        rd_chk("reset_rd3", 3, 0);
        led_chk("reset_led3", 3, 0);
        rst_n = 1'b0;

        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        status("idle_wr", 0, 1, 0, 0);
        rd_chk("idle_wr_mem0", 0, 0);

        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        status("fs1", 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        status("w15", 15, 0, 0, 1);
        cyc(1'b1, 8'h0F, 1'b0, 1'b0);
        status("full", 16, 0, 1, 0);
        rd_chk("full_rd5", 5, 32'h05);
        led_chk("full_led15", 15, 32'h0F);

        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        status("w17", 16, 1, 1, 0);
        rd_chk("w17_rd15", 15, 32'h0F);
        rd_chk("w17_rd0", 0, 32'h00);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        status("fs2", 0, 0, 0, 1);

        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0, 1'b1);
        status("fend", 3, 0, 1, 0);
        rd_chk("fend_rd2", 2, 32'hC3);
        rd_chk("fend_stale3", 3, 32'h03);
        led_chk("fend_led1", 1, 32'h32);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        status("fend_in_done", 3, 0, 1, 0);

        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        expect_v("w4_count", K_CNT, 32'd4);
        flush();
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        status("restart", 0, 0, 0, 1);
        rd_chk("restart_rd4", 4, 32'h04);
        rd_chk("restart_rd0", 0, 32'h10);

        led_sel = '0;
        rd_addr = '0;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        expect_v("mid_count", K_CNT, 32'd7);
        expect_v("mid_rd0", K_RD, 32'h20);
        flush();
        @(posedge pi_clk);
        #1;
        rst_n = 1'b1;
        #1;
        expect_v("async_count", K_CNT, 0);
        expect_v("async_valid", K_VAL, 0);
        expect_v("async_ready", K_RDY, 0);
        expect_v("async_ovf",   K_OVF, 0);
        expect_v("async_rd0",   K_RD,  0);
        expect_v("async_led0",  K_LED, 0);
        ->chk_ev;
        #1;
        for (int i = 1; i < 7; i++) rd_chk($sformatf("async_rd%0d", i), i, 0);
        rst_n = 1'b0;
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        status("after_rst", 0, 1, 0, 0);

        repeat (2) flush();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
